// File: rtl/board_display_pkg.sv
// Shared constants for the board display driver: segment table and defaults.
package board_display_pkg;

   localparam int DEF_N_DIGITS    = 4;
   localparam int DEF_REFRESH_DIV = 100000;

   // Active-low segments {CG,CF,CE,CD,CC,CB,CA}; all ones turns a digit dark.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Hex glyphs indexed by nibble value 0..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/board_display_hex7seg_decode.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex7seg_decode
   import board_display_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/board_display.sv
// Double-buffered hex display driver for a multiplexed common-anode
// 7-segment display. New values are committed only at frame wrap.
module board_display
   import board_display_pkg::*;
#(
   parameter int N_DIGITS    = DEF_N_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  en0,
   input  logic [4*N_DIGITS-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  blank_lz,
   input  logic [N_DIGITS-1:0]   dp_mask,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int DW    = 4 * N_DIGITS;
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DW-1:0]       shown_q, shown_d;
   logic [DW-1:0]       pend_buf_q, pend_buf_d;
   logic                pend_q, pend_d;
   logic                ready_q, ready_d;
   logic                tick_q, tick_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;

   logic          slot_end;
   logic          wrap;
   logic          xfer;
   logic [DW-1:0] shifted;
   logic          lead_zero;
   logic [6:0]    nib_seg;

   assign slot_end = (div_q == DIV_LAST);
   assign wrap     = slot_end && (idx_q == IDX_LAST);
   assign xfer     = din_valid && ready_q;

   // Current nibble sits in the low bits; an all-zero remainder means this
   // digit and everything left of it are leading zeros.
   assign shifted   = shown_q >> {idx_q, 2'b00};
   assign lead_zero = blank_lz && (idx_q != '0) && (shifted == '0);

   hex7seg_decode u_decode (
      .nib_i (shifted[3:0]),
      .seg_o (nib_seg)
   );

   // Next-state: refresh timing, double buffer handshake and digit drive.
   always_comb begin
      // NOTE: every _d takes a default first so no path leaves it unassigned and infers a latch.
      div_d      = slot_end ? '0 : div_q + 1'b1;
      idx_d      = idx_q;
      shown_d    = shown_q;
      pend_buf_d = pend_buf_q;
      pend_d     = pend_q;
      ready_d    = ready_q;
      tick_d     = wrap;

      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // Commit at wrap; ready is only low while pending, so a same-edge
      // transfer can never collide with a commit and lands in pending.
      if (wrap && pend_q) begin
         shown_d = pend_buf_q;
         pend_d  = 1'b0;
         ready_d = 1'b1;
      end

      if (xfer) begin
         pend_buf_d = din;
         pend_d     = 1'b1;
         ready_d    = 1'b0;
      end

      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = nib_seg;
      dp_d  = ~dp_mask[idx_q];

      if (lead_zero) begin
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end

      if (!en0) begin
         an_d  = '1;
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         div_q      <= '0;
         idx_q      <= '0;
         shown_q    <= '0;
         pend_buf_q <= '0;
         pend_q     <= 1'b0;
         ready_q    <= 1'b1;
         tick_q     <= 1'b0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         div_q      <= div_d;
         idx_q      <= idx_d;
         shown_q    <= shown_d;
         pend_buf_q <= pend_buf_d;
         pend_q     <= pend_d;
         ready_q    <= ready_d;
         tick_q     <= tick_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign din_ready  = ready_q;
   assign frame_tick = tick_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_board_display.sv
// Scoreboard bench for board_display: a cycle-count reference model pushes
// expected outputs on each rising edge; a monitor pops and compares them
// on the falling edge.
module tb_board_display;

   localparam int R = 4;
   localparam int N = 4;
   localparam int FRAME = R * N;

   logic        clk0 = 1'b0;
   logic        rst0;
   logic        en0;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        blank_lz;
   logic [3:0]  dp_mask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   board_display #(.N_DIGITS(N), .REFRESH_DIV(R)) dut (
      .clk0       (clk0),
      .rst0       (rst0),
      .en0        (en0),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .blank_lz   (blank_lz),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk0 = ~clk0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ready;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // Reference model state: cycles since reset, value on display, pending values.
   int          t;
   logic [15:0] m_shown;
   logic [15:0] m_pend[$];

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
   endtask

   // Reference model: predicts what the outputs hold after this edge.
   always @(posedge clk0) begin : model
      exp_t        e;
      int          digit;
      logic        wrap;
      logic        xfer;
      logic        blanked;
      logic [15:0] upper;
      if (rst0) begin
         t       = 0;
         m_shown = 16'h0;
         m_pend.delete();
         e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ready: 1'b1, tick: 1'b0};
      end else begin
         digit   = (t / R) % N;
         wrap    = (t % FRAME) == FRAME - 1;
         upper   = m_shown >> (4 * digit);
         blanked = blank_lz && (digit > 0) && (upper == 16'h0);
         if (!en0) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
         end else begin
            e.an  = ~(4'b0001 << digit);
            e.seg = blanked ? 7'h7F : hex_glyph(upper[3:0]);
            e.dp  = blanked ? 1'b1 : ~dp_mask[digit];
         end
         e.tick = wrap;
         xfer   = din_valid && (m_pend.size() == 0);
         if (wrap && m_pend.size() > 0) m_shown = m_pend.pop_front();
         if (xfer) m_pend.push_back(din);
         e.ready = (m_pend.size() == 0);
         t++;
      end
      exp_q.push_back(e);
   end

   // Monitor: compare DUT outputs away from the active edge.
   initial begin : monitor
      exp_t e;
      @(posedge clk0);
      forever begin
         @(negedge clk0);
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 16'd0, 16'd1);
         end else begin
            e = exp_q.pop_front();
            check("an",         16'(an),         16'(e.an));
            check("seg",        16'(seg),        16'(e.seg));
            check("dp",         16'(dp),         16'(e.dp));
            check("din_ready",  16'(din_ready),  16'(e.ready));
            check("frame_tick", 16'(frame_tick), 16'(e.tick));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk0);
         #1;
      end
   endtask

   // Advance until the next edge is at the given position in the frame.
   task automatic wait_phase(input int ph);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (t % FRAME == ph) return;
         step(1);
      end
      check("wait_phase_timeout", 16'd0, 16'd1);
   endtask

   task automatic offer(input logic [15:0] v);
      din       = v;
      din_valid = 1'b1;
      step(1);
      din_valid = 1'b0;
   endtask

   initial begin
      rst0      = 1'b1;
      en0       = 1'b1;
      din       = 16'h0;
      din_valid = 1'b0;
      blank_lz  = 1'b0;
      dp_mask   = 4'b0000;
      step(3);
      rst0 = 1'b0;

      // Idle scan of value 0.
      step(40);

      // Mid-frame offer.
      wait_phase(6);
      offer(16'h1A8F);
      step(40);

      // Transfer on the wrap edge, then an ignored offer while pending.
      wait_phase(FRAME - 1);
      offer(16'h0042);
      din       = 16'hFFFF;
      din_valid = 1'b1;
      step(5);
      din_valid = 1'b0;
      step(40);

      // Leading-zero blanking.
      blank_lz = 1'b1;
      offer(16'h0040);
      step(40);
      offer(16'h0000);
      step(40);
      blank_lz = 1'b0;

      // Display disabled mid-frame.
      wait_phase(5);
      en0 = 1'b0;
      step(10);
      en0 = 1'b1;
      step(20);

      // Reset while a value is pending.
      dp_mask = 4'b0001;
      wait_phase(2);
      offer(16'hABCD);
      step(2);
      rst0 = 1'b1;
      step(1);
      rst0 = 1'b0;
      step(40);

      // Randomized traffic.
      repeat (2000) begin
         din       = 16'($urandom);
         din_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom);
         en0  = ($urandom_range(0, 15) != 0);
         rst0 = ($urandom_range(0, 499) == 0);
         step(1);
      end
      rst0      = 1'b0;
      en0       = 1'b1;
      din_valid = 1'b0;
      step(5);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
